// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and defaults for the front-end redirect controller.
// Optional feature macro: REDIRECT_STATS_EN (redirect statistics counters).
package fetch_redirect_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH            = 32;
    localparam int unsigned REFILL_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFlush  = 2'd1,
        StRefill = 2'd2
    } redirect_state_t;

    typedef enum logic [1:0] {
        SrcNone = 2'd0,
        SrcExe0 = 2'd1,
        SrcExe1 = 2'd2,
        SrcDec  = 2'd3
    } redirect_src_t;

    // Branch feedback as seen from execute or decode (same fields on both).
    typedef struct packed {
        logic                  if_branch;
        logic                  if_prediction_correct;
        logic [ADDR_WIDTH-1:0] new_pc;
    } branch_fb_t;

    function automatic logic is_mispredict(input branch_fb_t fb);
        return fb.if_branch && !fb.if_prediction_correct;
    endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Combinational 3-way priority select: exe0 > exe1 > dec (dec only when enabled).
module redirect_prio_sel
    import fetch_redirect_ctrl_pkg::*;
(
    input  branch_fb_t            i_exe0,
    input  branch_fb_t            i_exe1,
    input  branch_fb_t            i_dec,
    input  logic                  i_dec_en,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output redirect_src_t         o_src
);

    // Pick the oldest mispredicting source.
    always_comb begin
        o_valid = 1'b0;
        o_pc    = '0;
        o_src   = SrcNone;
        if (is_mispredict(i_exe0)) begin
            o_valid = 1'b1;
            o_pc    = i_exe0.new_pc;
            o_src   = SrcExe0;
        end else if (is_mispredict(i_exe1)) begin
            o_valid = 1'b1;
            o_pc    = i_exe1.new_pc;
            o_src   = SrcExe1;
        end else if (i_dec_en && is_mispredict(i_dec)) begin
            o_valid = 1'b1;
            o_pc    = i_dec.new_pc;
            o_src   = SrcDec;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect sequencer: registers the highest-priority mispredict,
// pulses a flush, then stalls fetch for REFILL_CYCLES.
// Optional feature macro: REDIRECT_STATS_EN adds 32-bit redirect statistics.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned REFILL_CYCLES = REFILL_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ext_stall,
    input  logic                  ext_flush,
    input  branch_fb_t            i_branch [2],
    input  branch_fb_t            i_dec,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [1:0]            redirect_src,
    output logic                  flush_front,
    output logic                  fetch_stall,
    output logic                  busy
`ifdef REDIRECT_STATS_EN
    ,
    output logic [31:0]           stat_exe_redirects,
    output logic [31:0]           stat_dec_redirects,
    output logic [31:0]           stat_dec_dropped
`endif
);

    localparam logic [3:0] CntLoad = (REFILL_CYCLES == 0) ? 4'd0 : 4'(REFILL_CYCLES - 1);

    redirect_state_t       r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    redirect_src_t         r_src;

    logic                  w_sel_valid;
    logic [ADDR_WIDTH-1:0] w_sel_pc;
    redirect_src_t         w_sel_src;
    logic                  w_accept;

    // Decode feedback is wrong-path once a redirect sequence is in flight.
    redirect_prio_sel u_prio_sel (
        .i_exe0   (i_branch[0]),
        .i_exe1   (i_branch[1]),
        .i_dec    (i_dec),
        .i_dec_en (r_state == StIdle),
        .o_valid  (w_sel_valid),
        .o_pc     (w_sel_pc),
        .o_src    (w_sel_src)
    );

    assign w_accept = w_sel_valid && !ext_flush;

    // Next-state and refill counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (ext_flush) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 4'd0;
        end else if (w_accept) begin
            w_state_nxt = StFlush;
        end else begin
            case (r_state)
                StFlush: begin
                    if (REFILL_CYCLES == 0) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = StRefill;
                        w_cnt_nxt   = CntLoad;
                    end
                end
                StRefill: begin
                    if (!ext_stall) begin
                        if (r_cnt == 4'd0) begin
                            w_state_nxt = StIdle;
                        end else begin
                            w_cnt_nxt = r_cnt - 4'd1;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // State, counter and captured redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_pc    <= '0;
            r_src   <= SrcNone;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_pc  <= {w_sel_pc[ADDR_WIDTH-1:2], 2'b00};
                r_src <= w_sel_src;
            end
        end
    end

    // Outputs decode the state register; only the IDLE fetch stall is a passthrough.
    always_comb begin
        redirect_valid = (r_state == StFlush);
        flush_front    = (r_state == StFlush);
        busy           = (r_state != StIdle);
        fetch_stall    = 1'b0;
        case (r_state)
            StIdle:   fetch_stall = ext_stall;
            StRefill: fetch_stall = 1'b1;
            default:  fetch_stall = 1'b0;
        endcase
    end

    assign redirect_pc  = r_pc;
    assign redirect_src = r_src;

`ifdef REDIRECT_STATS_EN
    logic w_dec_drop;
    assign w_dec_drop = is_mispredict(i_dec) && (r_state != StIdle);

    // Wrapping statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_exe_redirects <= '0;
            stat_dec_redirects <= '0;
            stat_dec_dropped   <= '0;
        end else begin
            if (w_accept && (w_sel_src != SrcDec)) stat_exe_redirects <= stat_exe_redirects + 1'b1;
            if (w_accept && (w_sel_src == SrcDec)) stat_dec_redirects <= stat_dec_redirects + 1'b1;
            if (w_dec_drop) stat_dec_dropped <= stat_dec_dropped + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl (REFILL_CYCLES=2 and =0 instances).
// Honours REDIRECT_STATS_EN when defined.
module tb_fetch_redirect_ctrl;
    import fetch_redirect_ctrl_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [1:0]  src;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ext_stall_a, ext_flush_a;
    branch_fb_t  br_a [2];
    branch_fb_t  dec_a;
    logic        rv_a, ff_a, fs_a, busy_a;
    logic [31:0] pc_a;
    logic [1:0]  src_a;

    branch_fb_t  br_b [2];
    branch_fb_t  dec_b;
    logic        ext_stall_b, ext_flush_b;
    logic        rv_b, ff_b, fs_b, busy_b;
    logic [31:0] pc_b;
    logic [1:0]  src_b;

`ifdef REDIRECT_STATS_EN
    logic [31:0] st_exe_a, st_dec_a, st_drop_a;
    logic [31:0] st_exe_b, st_dec_b, st_drop_b;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   run_a    = 0;
    int   stall_b  = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   qrun[$];

    fetch_redirect_ctrl #(.REFILL_CYCLES(2)) u_dut_a (
        .clk            (clk),
        .reset          (reset),
        .ext_stall      (ext_stall_a),
        .ext_flush      (ext_flush_a),
        .i_branch       (br_a),
        .i_dec          (dec_a),
        .redirect_valid (rv_a),
        .redirect_pc    (pc_a),
        .redirect_src   (src_a),
        .flush_front    (ff_a),
        .fetch_stall    (fs_a),
        .busy           (busy_a)
`ifdef REDIRECT_STATS_EN
        ,
        .stat_exe_redirects (st_exe_a),
        .stat_dec_redirects (st_dec_a),
        .stat_dec_dropped   (st_drop_a)
`endif
    );

    fetch_redirect_ctrl #(.REFILL_CYCLES(0)) u_dut_b (
        .clk            (clk),
        .reset          (reset),
        .ext_stall      (ext_stall_b),
        .ext_flush      (ext_flush_b),
        .i_branch       (br_b),
        .i_dec          (dec_b),
        .redirect_valid (rv_b),
        .redirect_pc    (pc_b),
        .redirect_src   (src_b),
        .flush_front    (ff_b),
        .fetch_stall    (fs_b),
        .busy           (busy_b)
`ifdef REDIRECT_STATS_EN
        ,
        .stat_exe_redirects (st_exe_b),
        .stat_dec_redirects (st_dec_b),
        .stat_dec_dropped   (st_drop_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic branch_fb_t mp(input logic [31:0] pc);
        branch_fb_t fb;
        fb.if_branch             = 1'b1;
        fb.if_prediction_correct = 1'b0;
        fb.new_pc                = pc;
        return fb;
    endfunction

    task automatic clr();
        br_a[0] = '0;
        br_a[1] = '0;
        dec_a   = '0;
        br_b[0] = '0;
        br_b[1] = '0;
        dec_b   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input logic [31:0] pc, input logic [1:0] src);
        exp_t e;
        e.cyc = cyc + 1;
        e.pc  = pc;
        e.src = src;
        qa.push_back(e);
    endtask

    // Monitor: pops expected redirects on each pulse and expected stall-run lengths.
    always @(negedge clk) begin
        exp_t e;
        if (rv_a === 1'b1) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_redirect_a: got pc 0x%0h src %0d, expected none", pc_a,
                         src_a);
            end else begin
                e = qa.pop_front();
                check("redirect_cycle_a", cyc, e.cyc);
                check("redirect_pc_a", pc_a, e.pc);
                check("redirect_src_a", {30'd0, src_a}, {30'd0, e.src});
                check("flush_front_a", {31'd0, ff_a}, 32'd1);
            end
        end
        if (fs_a === 1'b1 && busy_a === 1'b1) begin
            run_a++;
        end else if (run_a > 0) begin
            if (qrun.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_stall_run: got %0d cycles, expected none", run_a);
            end else begin
                check("stall_run_len", run_a, qrun.pop_front());
            end
            run_a = 0;
        end
        if (rv_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_redirect_b: got pc 0x%0h, expected none", pc_b);
            end else begin
                e = qb.pop_front();
                check("redirect_cycle_b", cyc, e.cyc);
                check("redirect_pc_b", pc_b, e.pc);
                check("redirect_src_b", {30'd0, src_b}, {30'd0, e.src});
            end
        end
        if (fs_b === 1'b1) stall_b++;
    end

    initial begin
        exp_t eb;
        reset       = 1'b1;
        ext_stall_a = 1'b0;
        ext_flush_a = 1'b0;
        ext_stall_b = 1'b0;
        ext_flush_b = 1'b0;
        clr();
        repeat (3) step();
        @(negedge clk);
        check("reset_valid", {31'd0, rv_a}, 32'd0);
        check("reset_flush", {31'd0, ff_a}, 32'd0);
        check("reset_stall", {31'd0, fs_a}, 32'd0);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_pc", pc_a, 32'd0);
        check("reset_src", {30'd0, src_a}, 32'd0);
        step();
        reset = 1'b0;
        repeat (2) step();

        // Single exe0 redirect
        br_a[0] = mp(32'h100);
        expect_a(32'h100, 2'd1);
        qrun.push_back(2);
        step();
        clr();
        repeat (5) step();
        check("idle_after_seq", {31'd0, busy_a}, 32'd0);

        // Simultaneous sources: exe0 wins
        br_a[1] = mp(32'h200);
        dec_a   = mp(32'h300);
        br_a[0] = mp(32'h400);
        expect_a(32'h400, 2'd1);
        qrun.push_back(2);
        step();
        clr();
        repeat (5) step();

        // Decode mispredict during REFILL is dropped
        br_a[0] = mp(32'h100);
        expect_a(32'h100, 2'd1);
        qrun.push_back(2);
        step();
        clr();
        step();
        dec_a = mp(32'h500);
        step();
        clr();
        repeat (4) step();
`ifdef REDIRECT_STATS_EN
        check("stat_dec_dropped", st_drop_a, 32'd1);
        check("stat_exe_redirects", st_exe_a, 32'd3);
        check("stat_dec_redirects", st_dec_a, 32'd0);
`endif

        // exe1 during REFILL restarts at FLUSH
        br_a[0] = mp(32'h100);
        expect_a(32'h100, 2'd1);
        qrun.push_back(1);
        step();
        clr();
        step();
        br_a[1] = mp(32'h600);
        expect_a(32'h600, 2'd2);
        qrun.push_back(2);
        step();
        clr();
        repeat (5) step();

        // Back-to-back execute mispredicts
        br_a[0] = mp(32'hB00);
        expect_a(32'hB00, 2'd1);
        step();
        br_a[0] = '0;
        br_a[1] = mp(32'hC00);
        expect_a(32'hC00, 2'd2);
        qrun.push_back(2);
        step();
        clr();
        repeat (5) step();

        // ext_stall for 3 REFILL cycles stretches fetch_stall to 5
        br_a[0] = mp(32'h700);
        expect_a(32'h700, 2'd1);
        qrun.push_back(5);
        step();
        clr();
        step();
        ext_stall_a = 1'b1;
        repeat (3) step();
        ext_stall_a = 1'b0;
        repeat (5) step();

        // ext_flush mid-REFILL returns to IDLE without a pulse
        br_a[0] = mp(32'h800);
        expect_a(32'h800, 2'd1);
        qrun.push_back(1);
        step();
        clr();
        step();
        ext_flush_a = 1'b1;
        step();
        ext_flush_a = 1'b0;
        @(negedge clk);
        check("flush_abort_busy", {31'd0, busy_a}, 32'd0);
        repeat (3) step();

        // ext_flush beats a simultaneous execute mispredict
        br_a[0]     = mp(32'h900);
        ext_flush_a = 1'b1;
        step();
        clr();
        ext_flush_a = 1'b0;
        @(negedge clk);
        check("flush_vs_exe_busy", {31'd0, busy_a}, 32'd0);
        check("flush_vs_exe_pc_held", pc_a, 32'h800);
        repeat (3) step();

        // Lone exe1 and lone decode (IDLE) redirects
        br_a[1] = mp(32'h204);
        expect_a(32'h204, 2'd2);
        qrun.push_back(2);
        step();
        clr();
        repeat (5) step();
        dec_a = mp(32'h30C);
        expect_a(32'h30C, 2'd3);
        qrun.push_back(2);
        step();
        clr();
        repeat (5) step();

        // IDLE passes ext_stall straight through
        ext_stall_a = 1'b1;
        @(negedge clk);
        check("idle_stall_pass", {31'd0, fs_a}, 32'd1);
        check("idle_stall_busy", {31'd0, busy_a}, 32'd0);
        step();
        ext_stall_a = 1'b0;
        step();

        // Reset mid-sequence
        br_a[0] = mp(32'hA00);
        expect_a(32'hA00, 2'd1);
        qrun.push_back(1);
        step();
        clr();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'd0, rv_a}, 32'd0);
        check("midrst_stall", {31'd0, fs_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_pc", pc_a, 32'd0);
        check("midrst_src", {30'd0, src_a}, 32'd0);
`ifdef REDIRECT_STATS_EN
        check("midrst_stat_exe", st_exe_a, 32'd0);
        check("midrst_stat_drop", st_drop_a, 32'd0);
`endif
        repeat (2) step();

        // REFILL_CYCLES=0 instance, low PC bits masked
        br_b[0] = mp(32'h103);
        eb.cyc  = cyc + 1;
        eb.pc   = 32'h100;
        eb.src  = 2'd1;
        qb.push_back(eb);
        step();
        clr();
        repeat (2) step();
        @(negedge clk);
        check("b_busy_after", {31'd0, busy_b}, 32'd0);

        repeat (3) step();
        check("b_no_fetch_stall", stall_b, 0);
        check("qa_drained", qa.size(), 0);
        check("qrun_drained", qrun.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequences front-end redirects between the execute branch-feedback ports, the decode feedback port and the next-PC predictor/fetch stage. Each cycle it picks the highest-priority misprediction and registers it as a single redirect. It then runs a flush/refill sequence that stalls fetch for a fixed bubble. Decode redirects that arrive on the wrong path during that window are dropped.

## Interface
- `REFILL_CYCLES`, default 2: fetch-stall cycles after the flush cycle; legal range 0–15.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ext_stall` in 1: downstream stall; holds the state machine only in REFILL.
- `ext_flush` in 1: exception/trap flush; aborts any sequence and issues no redirect.
- `i_branch[2]` in `branch_fb_ifc.in`: execute feedback. Uses `if_branch`, `if_prediction_correct` and `new_pc`. Port 0 is older than port 1.
- `i_dec` in `branch_fb_decode_ifc.in`: decode feedback, same fields.
- `redirect_valid` out 1: one-cycle redirect pulse to the predictor/fetch stage.
- `redirect_pc` out `ADDR_WIDTH`: target PC, bits [1:0] forced to 0.
- `redirect_src` out 2: 0 none, 1 exe0, 2 exe1, 3 dec.
- `flush_front` out 1: kill the fetch and decode pipeline registers.
- `fetch_stall` out 1: hold the fetch PC.
- `busy` out 1: state is not IDLE.

## Operation
- Mispredict on port p: `if_branch && !if_prediction_correct`.
- Selection priority: exe0, then exe1, then dec. Exactly one source is accepted per cycle.
- States and transitions:
  - IDLE: an accepted mispredict goes to FLUSH.
  - FLUSH (exactly 1 cycle): goes to REFILL, or to IDLE if `REFILL_CYCLES==0`.
  - REFILL: 4-bit counter loads `REFILL_CYCLES-1` on entry. It decrements each cycle `ext_stall==0` and holds when `ext_stall==1`. Counter at 0 and not stalled goes to IDLE.
- Acceptance by state:
  - IDLE: any source.
  - FLUSH or REFILL: execute sources only; decode is dropped as wrong-path. An execute mispredict here restarts the sequence at FLUSH with the new target.
- Execute mispredict seen in the same cycle as `ext_flush`: `ext_flush` wins, the mispredict is discarded and the next state is IDLE.
- `redirect_pc` and `redirect_src` are registered together with the FLUSH entry. They hold their values until the next accepted redirect.
- Outputs by state:
  - FLUSH: `redirect_valid=1`, `flush_front=1`.
  - REFILL: `fetch_stall=1`.
  - IDLE: `fetch_stall=ext_stall`.
- `ext_flush` asserted in any state: next state IDLE, counter cleared, no `redirect_valid`.
- Reset values: state IDLE; `redirect_valid=0`, `flush_front=0`, `fetch_stall=0`, `busy=0`; `redirect_pc=0`, `redirect_src=0`; counter 0.

## Timing
- Latency 1: mispredict sampled at edge N gives `redirect_valid`/`flush_front` during cycle N+1.
- `fetch_stall` is high in cycles N+2 .. N+1+`REFILL_CYCLES`, extended by one cycle for each `ext_stall` cycle in REFILL.
- Back-to-back execute mispredicts on consecutive cycles give consecutive `redirect_valid` pulses, each carrying the newer target.
- All outputs are registered except `fetch_stall` in IDLE, which passes `ext_stall` combinationally.
- `reset` asserted mid-sequence returns every output to its reset value at the next edge.

## Configuration
- `REDIRECT_STATS_EN` defined:
  - Adds 32-bit wrapping counters `stat_exe_redirects`, `stat_dec_redirects` and `stat_dec_dropped` as outputs.
  - Each counter increments on acceptance, or on a dropped decode mispredict.
  - Counters clear on reset.
- `REDIRECT_STATS_EN` undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `riscv_core.svh` holds:
  - state enum `redirect_state_t` (IDLE, FLUSH, REFILL);
  - source encoding `redirect_src_t`;
  - default `REFILL_CYCLES_DEFAULT`.
- Sub-module `redirect_prio_sel`: a combinational 3-way priority select that returns the valid flag, PC and source from the three feedback ports plus a decode-enable input.

## Test plan
- Reset, then exe0 mispredict with `new_pc=0x100` → next cycle `redirect_valid=1`, `redirect_pc=0x100`, `redirect_src=1`, `flush_front=1`; then 2 cycles of `fetch_stall`; then IDLE.
- Same cycle: exe1 `0x200`, dec `0x300`, exe0 `0x400` → `redirect_pc=0x400`, `redirect_src=1`; no second pulse follows.
- exe0 redirect `0x100`, then dec mispredict `0x500` during REFILL → no redirect; `stat_dec_dropped=1` when `REDIRECT_STATS_EN` is defined.
- exe1 mispredict `0x600` during REFILL → FLUSH re-entered, `redirect_pc=0x600`, refill counter restarts.
- `ext_stall=1` for 3 cycles during REFILL → `fetch_stall` lasts 5 cycles; then `ext_flush` mid-REFILL → IDLE next cycle with no `redirect_valid`.
- `new_pc=0x103`, `REFILL_CYCLES=0` → `redirect_pc=0x100`; FLUSH goes directly to IDLE and `fetch_stall` stays 0.
